clause_loader: RTL and testbench

CLAUSE_LOADER -- requirements
Module: clause_loader

---
 rtl/clause_loader_pkg.sv | 24 ++
 rtl/clause_loader.sv | 132 +++++++++++++
 tb/tb_clause_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clause_loader_pkg.sv
// rtl/clause_loader_pkg.sv - shared types and default capacities for the clause loader
package clause_loader_pkg;

  // Default capacities of the downstream clause store.
  localparam int DEF_MAX_CLAUSES    = 256;
  localparam int DEF_MAX_LITS       = 4096;
  localparam int DEF_MAX_CLAUSE_LEN = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } loader_state_t;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_CLAUSE_OVF   = 3'd1,
    ERR_LIT_OVF      = 3'd2,
    ERR_CLAUSE_LONG  = 3'd3,
    ERR_UNTERMINATED = 3'd4
  } err_code_t;

endpackage

// File: rtl/clause_loader.sv
// rtl/clause_loader.sv - streams DIMACS literals into a clause store write port
module clause_loader
  import clause_loader_pkg::*;
#(
  parameter int MAX_CLAUSES    = DEF_MAX_CLAUSES,
  parameter int MAX_LITS       = DEF_MAX_LITS,
  parameter int MAX_CLAUSE_LEN = DEF_MAX_CLAUSE_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_literal,
  input  logic               in_last,
  output logic               wr_en,
  output logic [15:0]        wr_clause_id,
  output logic [15:0]        wr_lit_count,
  output logic [15:0]        wr_clause_start,
  output logic [15:0]        wr_clause_len,
  output logic [15:0]        wr_lit_addr,
  output logic signed [31:0] wr_literal,
  output logic [15:0]        num_clauses,
  output logic [15:0]        num_lits,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2:0]         err_code
);

  localparam logic [15:0] CLAUSE_CAP = 16'(MAX_CLAUSES);
  localparam logic [15:0] LIT_CAP    = 16'(MAX_LITS);
  localparam logic [15:0] LEN_CAP    = 16'(MAX_CLAUSE_LEN);

  loader_state_t state;
  err_code_t     err;
  logic [15:0]   clause_id;
  logic [15:0]   lit_ptr;
  logic [15:0]   cur_len;
  logic [15:0]   cur_start;
  logic          lit_nonzero;

  assign lit_nonzero = (in_literal != 32'sd0);

  // Status flags decode straight from the state register.
  assign in_ready    = (state == ST_LOAD);
  assign busy        = (state == ST_LOAD);
  assign done        = (state == ST_DONE);
  assign error       = (state == ST_ERROR);
  assign err_code    = err;
  assign num_clauses = clause_id;
  assign num_lits    = lit_ptr;

  // Loader FSM: owns the counters and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      err             <= ERR_NONE;
      clause_id       <= '0;
      lit_ptr         <= '0;
      cur_len         <= '0;
      cur_start       <= '0;
      wr_en           <= 1'b0;
      wr_clause_id    <= '0;
      wr_lit_count    <= '0;
      wr_clause_start <= '0;
      wr_clause_len   <= '0;
      wr_lit_addr     <= '0;
      wr_literal      <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state     <= ST_LOAD;
            err       <= ERR_NONE;
            clause_id <= '0;
            lit_ptr   <= '0;
            cur_len   <= '0;
            cur_start <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (lit_nonzero) begin
              // Capacity checks in priority order; a rejected literal is never written.
              if (clause_id == CLAUSE_CAP) begin
                state <= ST_ERROR;
                err   <= ERR_CLAUSE_OVF;
              end else if (lit_ptr == LIT_CAP) begin
                state <= ST_ERROR;
                err   <= ERR_LIT_OVF;
              end else if (cur_len == LEN_CAP) begin
                state <= ST_ERROR;
                err   <= ERR_CLAUSE_LONG;
              end else begin
                // Each write carries the running length so the store ends up with the final one.
                wr_en           <= 1'b1;
                wr_literal      <= in_literal;
                wr_lit_addr     <= lit_ptr;
                wr_clause_id    <= clause_id;
                wr_clause_start <= cur_start;
                wr_clause_len   <= cur_len + 16'd1;
                wr_lit_count    <= lit_ptr + 16'd1;
                lit_ptr         <= lit_ptr + 16'd1;
                cur_len         <= cur_len + 16'd1;
                if (in_last) begin
                  state <= ST_ERROR;
                  err   <= ERR_UNTERMINATED;
                end
              end
            end else begin
              // Terminator commits a non-empty clause; empty clauses are dropped silently.
              if (cur_len != 16'd0) begin
                clause_id <= clause_id + 16'd1;
                cur_start <= lit_ptr;
                cur_len   <= '0;
              end
              if (in_last) begin
                state <= ST_DONE;
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clause_loader.sv
// tb/tb_clause_loader.sv - randomized scoreboard bench for clause_loader
module tb_clause_loader;

  localparam int MC  = 8;
  localparam int ML  = 24;
  localparam int MCL = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_literal = '0;
  logic               in_last = 1'b0;
  logic               wr_en;
  logic [15:0]        wr_clause_id, wr_lit_count, wr_clause_start, wr_clause_len, wr_lit_addr;
  logic signed [31:0] wr_literal;
  logic [15:0]        num_clauses, num_lits;
  logic               busy, done, error;
  logic [2:0]         err_code;

  clause_loader #(.MAX_CLAUSES(MC), .MAX_LITS(ML), .MAX_CLAUSE_LEN(MCL)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_literal(in_literal), .in_last(in_last), .wr_en(wr_en), .wr_clause_id(wr_clause_id),
    .wr_lit_count(wr_lit_count), .wr_clause_start(wr_clause_start), .wr_clause_len(wr_clause_len),
    .wr_lit_addr(wr_lit_addr), .wr_literal(wr_literal), .num_clauses(num_clauses),
    .num_lits(num_lits), .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] id;
    logic [15:0] cnt;
    logic [15:0] cstart;
    logic [15:0] len;
    logic [15:0] addr;
    logic [31:0] lit;
  } wr_t;

  wr_t sb[$];
  int  q_lit[$];
  bit  q_last[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  exp_consumed, exp_ncl, exp_nlit, exp_code;
  bit  exp_done, exp_err;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Reference: walk the formula clause by clause and list the writes the store must see.
  task automatic model_run();
    int ncl = 0, nlit = 0, clen = 0, cstart = 0;
    bit stop = 0;
    exp_done = 0; exp_err = 0; exp_code = 0; exp_consumed = 0;
    foreach (q_lit[i]) begin
      if (!stop) begin
        exp_consumed++;
        if (q_lit[i] != 0) begin
          if (ncl == MC) begin exp_err = 1; exp_code = 1; stop = 1; end
          else if (nlit == ML) begin exp_err = 1; exp_code = 2; stop = 1; end
          else if (clen == MCL) begin exp_err = 1; exp_code = 3; stop = 1; end
          else begin
            sb.push_back('{id: 16'(ncl), cnt: 16'(nlit + 1), cstart: 16'(cstart),
                           len: 16'(clen + 1), addr: 16'(nlit), lit: 32'(q_lit[i])});
            nlit++;
            clen++;
            if (q_last[i]) begin exp_err = 1; exp_code = 4; stop = 1; end
          end
        end else begin
          if (clen > 0) begin ncl++; cstart = nlit; clen = 0; end
          if (q_last[i]) begin exp_done = 1; stop = 1; end
        end
      end
    end
    exp_ncl = ncl;
    exp_nlit = nlit;
  endtask

  // Monitor: every write the DUT presents must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (wr_en) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {wr_clause_id, wr_lit_addr, wr_literal}, 160'd0);
        end else begin
          check("write", {wr_clause_id, wr_lit_count, wr_clause_start, wr_clause_len, wr_lit_addr, wr_literal},
                sb.pop_front());
        end
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_clears", {busy, done, error, err_code, num_clauses, num_lits},
          {1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0});
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input int lit, input bit last, input bit allow_start);
    int waited = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    if (allow_start && $urandom_range(0, 5) == 0) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b1; in_literal = lit; in_last = last;
    @(negedge clk);
    while (!in_ready && waited < 50) begin @(negedge clk); waited++; end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL ready_timeout actual=in_ready_low required=in_ready_high");
    end else begin
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0; in_literal = '0; in_last = 1'b0;
  endtask

  task automatic run_formula(input bit allow_mid_start);
    model_run();
    do_start();
    for (int i = 0; i < exp_consumed; i++) send_beat(q_lit[i], q_last[i], allow_mid_start && i > 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("writes_drained", 160'(sb.size()), 160'd0);
    check("status", {done, error, err_code, num_clauses, num_lits, in_ready, busy},
          {exp_done, exp_err, 3'(exp_code), 16'(exp_ncl), 16'(exp_nlit), 1'b0, 1'b0});
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic set_beats(input int lits[$], input int last_idx);
    q_lit = lits;
    q_last.delete();
    foreach (lits[i]) q_last.push_back(i == last_idx);
  endtask

  task automatic gen_random();
    int ncl, len, v;
    q_lit.delete(); q_last.delete();
    ncl = $urandom_range(1, 10);
    for (int c = 0; c < ncl; c++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 4);
      for (int k = 0; k < len; k++) begin
        v = $urandom_range(1, 5000);
        if ($urandom_range(0, 1) == 1) v = -v;
        q_lit.push_back(v); q_last.push_back(0);
      end
      q_lit.push_back(0); q_last.push_back(0);
      if ($urandom_range(0, 5) == 0) begin q_lit.push_back(0); q_last.push_back(0); end
    end
    if ($urandom_range(0, 4) == 0) begin
      q_lit.push_back(int'($urandom_range(1, 99))); q_last.push_back(1);
    end else begin
      q_last[q_last.size() - 1] = 1;
    end
  endtask

  initial begin
    int lits[$];
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {in_ready, wr_en, wr_clause_id, wr_lit_count, wr_clause_start, wr_clause_len,
          wr_lit_addr, wr_literal, num_clauses, num_lits, busy, done, error, err_code}, 160'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    lits = '{1, -2, 0, 3, 0};
    set_beats(lits, 4);
    run_formula(0);
    check("basic_counts", {num_clauses, num_lits, done}, {16'd2, 16'd3, 1'b1});

    lits = '{5, 0, 0, 0, -6, 0};
    set_beats(lits, 5);
    run_formula(0);
    check("empty_clauses", {num_clauses, done}, {16'd2, 1'b1});

    lits.delete();
    for (int i = 1; i <= 17; i++) lits.push_back(i);
    lits.push_back(0);
    set_beats(lits, 17);
    run_formula(0);
    check("too_long", {error, err_code, num_lits, in_ready}, {1'b1, 3'd3, 16'd16, 1'b0});

    lits.delete();
    for (int c = 0; c < 3; c++) begin
      for (int i = 1; i <= 8; i++) lits.push_back(i);
      lits.push_back(0);
    end
    lits.push_back(9);
    lits.push_back(0);
    set_beats(lits, 28);
    run_formula(0);
    check("lit_overflow", {error, err_code, num_lits}, {1'b1, 3'd2, 16'd24});

    lits.delete();
    for (int c = 0; c < 8; c++) begin
      lits.push_back(c + 1); lits.push_back(-(c + 1)); lits.push_back(c + 50); lits.push_back(0);
    end
    lits.push_back(77);
    lits.push_back(0);
    set_beats(lits, 33);
    run_formula(0);
    check("clause_overflow_priority", {error, err_code, num_clauses, num_lits}, {1'b1, 3'd1, 16'd8, 16'd24});

    lits = '{1, 2};
    set_beats(lits, 1);
    run_formula(1);
    check("unterminated", {error, err_code, num_lits}, {1'b1, 3'd4, 16'd2});

    lits = '{11, 12};
    set_beats(lits, -1);
    model_run();
    do_start();
    send_beat(11, 0, 0);
    send_beat(12, 0, 0);
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_load_reset", {in_ready, wr_en, wr_clause_id, wr_lit_count, wr_clause_start, wr_clause_len,
          wr_lit_addr, wr_literal, num_clauses, num_lits, busy, done, error, err_code}, 160'd0);
    check("reset_writes_drained", 160'(sb.size()), 160'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    lits = '{7, 0};
    set_beats(lits, 1);
    run_formula(0);
    check("after_reset", {done, num_clauses, num_lits}, {1'b1, 16'd1, 16'd1});

    for (int t = 0; t < 40; t++) begin
      gen_random();
      run_formula(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
